dpram_port_arbiter: RTL and testbench

- Front-end controller that sits between two independent requesters (clients A and B) and the two ports of the team's dual-port RAM.
- It forwards non-conflicting accesses to both RAM ports in the same cycle.
- When both clients hit the same address and at least one is writing, it serialises them with round-robin priority.
- It generates one-cycle-latency read responses and counts conflicts for performance monitoring.

---
 rtl/dpram_port_arbiter.sv | 94 +++++++++
 tb/tb_dpram_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// Two-client front end for a dual-port RAM: pass-through when accesses do not collide,
// round-robin serialisation on same-address conflicts involving a write.
module dpram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // client A
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  // client B
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  // RAM port A
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  // RAM port B
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  // status
  output logic [CNT_WIDTH-1:0]  conflict_cnt,
  output logic                  prio_b
);

  logic                 conflict;
  logic                 prio_q, prio_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 a_rvalid_q, a_rvalid_d;
  logic                 b_rvalid_q, b_rvalid_d;

  always_comb begin
    conflict = a_valid & b_valid & (a_addr == b_addr) & (a_we | b_we);

    // The loser of a conflict becomes the priority holder for the next one.
    a_ready = ~rst & (~conflict | ~prio_q);
    b_ready = ~rst & (~conflict | prio_q);

    ram_we_a   = a_valid & a_ready & a_we;
    ram_addr_a = a_addr;
    ram_din_a  = a_wdata;
    ram_we_b   = b_valid & b_ready & b_we;
    ram_addr_b = b_addr;
    ram_din_b  = b_wdata;

    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (conflict) begin
      prio_d = ~prio_q;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    a_rvalid_d = a_valid & a_ready & ~a_we;
    b_rvalid_d = b_valid & b_ready & ~b_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // A response pending when reset arrives is dropped immediately.
  assign a_rvalid     = a_rvalid_q & ~rst;
  assign b_rvalid     = b_rvalid_q & ~rst;
  assign a_rdata      = ram_dout_a;
  assign b_rdata      = ram_dout_b;
  assign conflict_cnt = cnt_q;
  assign prio_b       = prio_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural dual-port RAM and a read-response
// scoreboard; a second instance with a 2-bit counter checks saturation.
module tb_dpram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_we, b_valid, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, b_ready, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we_a, ram_we_b;
  logic [3:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_din_a, ram_din_b;
  logic [7:0] ram_dout_a, ram_dout_b;
  logic [15:0] conflict_cnt;
  logic       prio_b;

  // small-counter instance outputs
  logic       s_a_ready, s_b_ready, s_a_rvalid, s_b_rvalid;
  logic [7:0] s_a_rdata, s_b_rdata;
  logic       s_ram_we_a, s_ram_we_b;
  logic [3:0] s_ram_addr_a, s_ram_addr_b;
  logic [7:0] s_ram_din_a, s_ram_din_b;
  logic [1:0] s_conflict_cnt;
  logic       s_prio_b;

  logic [7:0] mem [16];
  logic [7:0] qa[$], qb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_dout_a(ram_dout_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b),
    .conflict_cnt(conflict_cnt), .prio_b(prio_b)
  );

  dpram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(s_a_rvalid), .a_rdata(s_a_rdata),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(s_b_rvalid), .b_rdata(s_b_rdata),
    .ram_we_a(s_ram_we_a), .ram_addr_a(s_ram_addr_a), .ram_din_a(s_ram_din_a),
    .ram_dout_a(ram_dout_a),
    .ram_we_b(s_ram_we_b), .ram_addr_b(s_ram_addr_b), .ram_din_b(s_ram_din_b),
    .ram_dout_b(ram_dout_b),
    .conflict_cnt(s_conflict_cnt), .prio_b(s_prio_b)
  );

  // Read-first dual-port RAM with registered outputs, preloaded with 0x10 + addr.
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

  always @(posedge clk) begin
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid pops the oldest expected read data.
  always @(negedge clk) begin
    if (a_rvalid === 1'b1) begin
      if (qa.size() == 0) chk("a_rvalid unexpected", 32'(a_rvalid), 32'd0);
      else chk("a_rdata", 32'(a_rdata), 32'(qa.pop_front()));
    end
    if (b_rvalid === 1'b1) begin
      if (qb.size() == 0) chk("b_rvalid unexpected", 32'(b_rvalid), 32'd0);
      else chk("b_rdata", 32'(b_rdata), 32'(qb.pop_front()));
    end
  end

  task automatic drive(input logic av, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                       input logic bv, input logic bw, input logic [3:0] ba, input logic [7:0] bd);
    a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd1, 8'hFF, 1'b1, 1'b1, 4'd6, 8'hFF);
    step();
    @(negedge clk);
    chk("reset a_ready", 32'(a_ready), 32'd0);
    chk("reset b_ready", 32'(b_ready), 32'd0);
    chk("reset ram_we_a", 32'(ram_we_a), 32'd0);
    chk("reset ram_we_b", 32'(ram_we_b), 32'd0);
    chk("reset prio_b", 32'(prio_b), 32'd0);
    chk("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("reset a_rvalid", 32'(a_rvalid), 32'd0);
    chk("reset b_rvalid", 32'(b_rvalid), 32'd0);
    step();
    rst = 1'b0;

    // 1: A writes 3, B reads 7 -> no conflict
    drive(1'b1, 1'b1, 4'd3, 8'h5A, 1'b1, 1'b0, 4'd7, 8'h00);
    qb.push_back(8'h17);
    @(negedge clk);
    chk("t1 a_ready", 32'(a_ready), 32'd1);
    chk("t1 b_ready", 32'(b_ready), 32'd1);
    chk("t1 ram_we_a", 32'(ram_we_a), 32'd1);
    chk("t1 ram_we_b", 32'(ram_we_b), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("t1 b_rvalid", 32'(b_rvalid), 32'd1);
    chk("t1 conflict_cnt", 32'(conflict_cnt), 32'd0);
    step();

    // 2: both write 5, A wins then B
    drive(1'b1, 1'b1, 4'd5, 8'h11, 1'b1, 1'b1, 4'd5, 8'h22);
    @(negedge clk);
    chk("t2 a_ready", 32'(a_ready), 32'd1);
    chk("t2 b_ready", 32'(b_ready), 32'd0);
    chk("t2 ram_we_b", 32'(ram_we_b), 32'd0);
    step();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd5, 8'h22);
    @(negedge clk);
    chk("t2 b_ready retry", 32'(b_ready), 32'd1);
    chk("t2 prio_b", 32'(prio_b), 32'd1);
    chk("t2 conflict_cnt", 32'(conflict_cnt), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("t2 mem5", 32'(mem[5]), 32'h22);
    chk("t2 prio_b hold", 32'(prio_b), 32'd1);
    step();

    // 3: A write 2 vs B read 2 with prio_b = 1
    drive(1'b1, 1'b1, 4'd2, 8'hAA, 1'b1, 1'b0, 4'd2, 8'h00);
    qb.push_back(8'h12);
    @(negedge clk);
    chk("t3 a_ready", 32'(a_ready), 32'd0);
    chk("t3 b_ready", 32'(b_ready), 32'd1);
    chk("t3 ram_we_a", 32'(ram_we_a), 32'd0);
    step();
    drive(1'b1, 1'b1, 4'd2, 8'hAA, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    chk("t3 a_ready retry", 32'(a_ready), 32'd1);
    chk("t3 ram_we_a retry", 32'(ram_we_a), 32'd1);
    chk("t3 prio_b", 32'(prio_b), 32'd0);
    chk("t3 conflict_cnt", 32'(conflict_cnt), 32'd2);
    step();
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
    qa.push_back(8'h22);
    qb.push_back(8'hAA);
    @(negedge clk);
    chk("t3 a_ready read", 32'(a_ready), 32'd1);
    chk("t3 b_ready read", 32'(b_ready), 32'd1);
    step();

    // 4: both read 9 -> not a conflict
    drive(1'b1, 1'b0, 4'd9, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
    qa.push_back(8'h19);
    qb.push_back(8'h19);
    @(negedge clk);
    chk("t4 a_ready", 32'(a_ready), 32'd1);
    chk("t4 b_ready", 32'(b_ready), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("t4 a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t4 b_rvalid", 32'(b_rvalid), 32'd1);
    chk("t4 conflict_cnt", 32'(conflict_cnt), 32'd2);
    chk("t4 prio_b", 32'(prio_b), 32'd0);
    step();

    // 5: fresh reset, then 10 cycles of same-address writes
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 4'd4, 8'hA0, 1'b1, 1'b1, 4'd4, 8'hB0);
      @(negedge clk);
      chk("t5 a_ready", 32'(a_ready), 32'(i % 2 == 0));
      chk("t5 b_ready", 32'(b_ready), 32'(i % 2 == 1));
      chk("t5 prio_b", 32'(prio_b), 32'(i % 2));
      chk("t5 conflict_cnt", 32'(conflict_cnt), 32'(i));
      chk("t5 small cnt", 32'(s_conflict_cnt), (i > 3) ? 32'd3 : 32'(i));
      step();
    end
    idle();
    @(negedge clk);
    chk("t5 final cnt", 32'(conflict_cnt), 32'd10);
    chk("t5 small saturated", 32'(s_conflict_cnt), 32'd3);
    chk("t5 prio_b", 32'(prio_b), 32'd0);
    chk("t5 mem4", 32'(mem[4]), 32'hB0);
    step();

    // 6: read accepted, then reset -> response dropped, no writes
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    chk("t6 a_ready", 32'(a_ready), 32'd1);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd4, 8'hEE, 1'b1, 1'b1, 4'd4, 8'hEE);
    @(negedge clk);
    chk("t6 a_rvalid dropped", 32'(a_rvalid), 32'd0);
    chk("t6 a_ready", 32'(a_ready), 32'd0);
    chk("t6 b_ready", 32'(b_ready), 32'd0);
    chk("t6 ram_we_a", 32'(ram_we_a), 32'd0);
    chk("t6 ram_we_b", 32'(ram_we_b), 32'd0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("t6 prio_b", 32'(prio_b), 32'd0);
    chk("t6 conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("t6 a_rvalid", 32'(a_rvalid), 32'd0);
    chk("t6 mem4", 32'(mem[4]), 32'hB0);
    step();
    step();

    chk("qa drained", 32'(qa.size()), 32'd0);
    chk("qb drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
